// File: rtl/logic_unit_pkg.sv
// Shared encodings for the pipelined logic unit: gate select and reduction mode.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_NOR     = 3'd2;
  localparam logic [2:0] OP_NAND    = 3'd3;
  localparam logic [2:0] OP_XOR     = 3'd4;
  localparam logic [2:0] OP_NOT     = 3'd5;
  localparam logic [2:0] OP_XNOR    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam logic [1:0] RED_NONE = 2'b00;
  localparam logic [1:0] RED_AND  = 2'b01;
  localparam logic [1:0] RED_OR   = 2'b10;
  localparam logic [1:0] RED_XOR  = 2'b11;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle; slave is the logic unit, master is the producer/consumer side.
interface logic_unit_pipe_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic [1:0]       red;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             err;

  modport slave (
    input  in_valid, a, b, op, red, out_ready,
    output in_ready, out_valid, y, err
  );

  modport master (
    output in_valid, a, b, op, red, out_ready,
    input  in_ready, out_valid, y, err
  );

endinterface

// File: rtl/logic_unit_core.sv
// Combinational WIDTH-bit gate: applies the selected bitwise op, forcing zero for the illegal code.
import logic_unit_pkg::*;

module logic_unit_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             illegal
);

  assign illegal = (op == OP_ILLEGAL);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic r;
    always_comb begin
      r = 1'b0;
      case (op)
        OP_AND:  r = a[gi] & b[gi];
        OP_OR:   r = a[gi] | b[gi];
        OP_NOR:  r = ~(a[gi] | b[gi]);
        OP_NAND: r = ~(a[gi] & b[gi]);
        OP_XOR:  r = a[gi] ^ b[gi];
        OP_NOT:  r = ~a[gi];
        OP_XNOR: r = ~(a[gi] ^ b[gi]);
        default: r = 1'b0;
      endcase
    end
    assign res[gi] = r;
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage logic unit: S1 registers the gate result, S2 applies the optional reduction.
// Both stages use skid-free valid/ready advance; a saturating counter tracks output handshakes.
import logic_unit_pkg::*;

module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  logic_unit_pipe_if.slave   bus,
  output logic [CNT_W-1:0]   txn_count
);

  logic [WIDTH-1:0] core_res;
  logic             core_illegal;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_res_q;
  logic [1:0]       s1_red_q;
  logic             s1_err_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_y_q;
  logic [WIDTH-1:0] s2_y_d;
  logic             s2_err_q;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic s1_adv;
  logic s2_adv;
  logic in_xfer;
  logic out_xfer;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .a       (bus.a),
    .b       (bus.b),
    .op      (bus.op),
    .res     (core_res),
    .illegal (core_illegal)
  );

  assign s2_adv   = !s2_valid_q || bus.out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_xfer  = bus.in_valid && s1_adv;
  assign out_xfer = s2_valid_q && bus.out_ready;

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.y         = s2_y_q;
  assign bus.err       = s2_err_q;
  assign txn_count     = cnt_q;

  // Reduced results occupy bit 0 only; the illegal op already delivers a zero vector to reduce.
  always_comb begin
    s2_y_d = '0;
    case (s1_red_q)
      RED_NONE: s2_y_d    = s1_res_q;
      RED_AND:  s2_y_d[0] = &s1_res_q;
      RED_OR:   s2_y_d[0] = |s1_res_q;
      RED_XOR:  s2_y_d[0] = ^s1_res_q;
      default:  s2_y_d    = s1_res_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_res_q   <= '0;
      s1_red_q   <= RED_NONE;
      s1_err_q   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (in_xfer) begin
        s1_res_q <= core_res;
        s1_red_q <= bus.red;
        s1_err_q <= core_illegal;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_err_q   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_y_q   <= s2_y_d;
        s2_err_q <= s1_err_q;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_xfer && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: expected beats are queued at input handshake and checked at output handshake.
module tb_logic_unit_pipe;

  logic clk;
  logic rst;

  logic_unit_pipe_if #(.WIDTH(8)) bus ();
  logic_unit_pipe_if #(.WIDTH(8)) bus2 ();
  logic [15:0] txn_count;
  logic [2:0]  txn_count2;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .txn_count (txn_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(3)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .txn_count (txn_count2)
  );

  typedef struct {
    logic [7:0] y;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;
  int   n_out = 0;
  int   n_out2 = 0;
  bit   lat_chk = 0;
  bit   sat_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference: gate result, illegal flag, then reduction into bit 0.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op, input logic [1:0] red);
    logic [7:0] r;
    logic       e;
    logic [7:0] y;
    e = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~(a | b);
      3'd3: r = ~(a & b);
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: r = ~(a ^ b);
      default: begin r = 8'h00; e = 1'b1; end
    endcase
    case (red)
      2'b01:   y = {7'b0, &r};
      2'b10:   y = {7'b0, |r};
      2'b11:   y = {7'b0, ^r};
      default: y = r;
    endcase
    return {e, y};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        logic [8:0] m;
        m = model(bus.a, bus.b, bus.op, bus.red);
        e.y   = m[7:0];
        e.err = m[8];
        e.cyc = cyc;
        sb.push_back(e);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        $display("txn %0d: y=%02h err=%0b", n_out, bus.y, bus.err);
        if (sb.size() == 0) begin
          check_val("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_val("y", 32'(bus.y), 32'(e.y));
          check_val("err", 32'(bus.err), 32'(e.err));
          if (lat_chk) check_val("latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
      if (sat_run && bus2.out_valid && bus2.out_ready) begin
        n_out2++;
        $display("sat txn %0d: y=%02h count=%0d", n_out2, bus2.y, txn_count2);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic [1:0] red);
    int waited;
    waited = 0;
    bus.a = a; bus.b = b; bus.op = op; bus.red = red;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) check_val("send_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    @(negedge clk);
    while (sb.size() != 0 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (sb.size() != 0) check_val("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.op = 0; bus.red = 0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.a = 0; bus2.b = 0; bus2.op = 0; bus2.red = 0; bus2.out_ready = 0;
    #2 rst = 1'b1;
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_y", 32'(bus.y), 32'd0);
    check_val("rst_err", 32'(bus.err), 32'd0);
    check_val("rst_txn", 32'(txn_count), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.a = 8'hFF; bus.b = 8'hFF; bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // All seven legal gates, back to back.
    lat_chk = 1;
    for (int i = 0; i < 7; i++) send(8'hF0, 8'h3C, 3'(i), 2'b00);
    drain();
    lat_chk = 0;
    check_val("txn_after_ops", 32'(txn_count), 32'd7);

    send(8'hFF, 8'hFF, 3'd0, 2'b01);
    send(8'h00, 8'h00, 3'd1, 2'b10);
    send(8'h07, 8'h00, 3'd4, 2'b11);
    drain();

    send(8'hAA, 8'h55, 3'd7, 2'b00);
    send(8'h0F, 8'hF0, 3'd1, 2'b00);
    drain();

    // Backpressure: two beats fill the pipe, the third is refused until release.
    bus.out_ready = 1'b0;
    send(8'h5A, 8'h0F, 3'd0, 2'b00);
    send(8'h33, 8'h0F, 3'd4, 2'b00);
    bus.a = 8'h81; bus.b = 8'h18; bus.op = 3'd6; bus.red = 2'b00; bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_val("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check_val("bp_y_hold", 32'(bus.y), 32'h0A);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 32'(bus.in_ready), 32'd1);
    send(8'h81, 8'h18, 3'd6, 2'b00);
    send(8'h12, 8'h34, 3'd3, 2'b00);
    drain();
    check_val("txn_before_rst", 32'(txn_count), 32'd16);

    // Asynchronous reset with two beats in flight.
    bus.out_ready = 1'b0;
    send(8'hC3, 8'h81, 3'd1, 2'b00);
    send(8'h11, 8'h22, 3'd1, 2'b00);
    @(negedge clk);
    check_val("inflight_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("arst_y", 32'(bus.y), 32'd0);
    check_val("arst_txn", 32'(txn_count), 32'd0);
    check_val("arst_in_ready", 32'(bus.in_ready), 32'd1);
    sb.delete();
    bus.a = 8'hEE; bus.b = 8'h77; bus.op = 3'd0; bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_val("rel_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_val("no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Saturating counter on the CNT_W=3 instance.
    @(posedge clk);
    #1;
    sat_run = 1;
    bus2.a = 8'h0F; bus2.b = 8'hFF; bus2.op = 3'd0; bus2.out_ready = 1'b1; bus2.in_valid = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sat_run = 0;
    check_val("sat_xfers_ge10", 32'(n_out2 >= 10), 32'd1);
    check_val("sat_txn", 32'(txn_count2), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
